// File: rtl/currctrl_debug_capture_ctrl.sv
// Current-control debug capture: streams samples into a debug RAM around a trigger, CSR controlled.
// Optional macro CURRCTRL_CAPTURE_TIMESTAMP_EN replaces the top sample byte with an 8-bit timestamp.
module currctrl_debug_capture_ctrl #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trig_in,
  input  logic [1:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_post_count;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_wrapped;
  logic              r_triggered;
  logic              r_irq;
  logic              r_done_pulse;
  logic              r_ram_write;
  logic [ADDR_W-1:0] r_ram_address;
  logic [DATA_W-1:0] r_ram_writedata;

  logic              w_ctrl_wr;
  logic              w_abort;
  logic              w_arm;
  logic              w_irq_clr;
  logic              w_pc_wr;
  logic [ADDR_W-1:0] w_pc_sat;
  logic              w_capture;
  logic              w_trig;
  logic              w_post_last;
  logic              w_enter_done;
  logic [DATA_W-1:0] w_wdata;

  // Command decode; ABORT suppresses both ARM and any same-cycle capture.
  assign w_ctrl_wr    = csr_write && (csr_address == 2'd0);
  assign w_abort      = w_ctrl_wr && csr_writedata[1];
  assign w_arm        = w_ctrl_wr && csr_writedata[0] && !w_abort &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_irq_clr    = w_ctrl_wr && csr_writedata[2];
  assign w_pc_wr      = csr_write && (csr_address == 2'd1) &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_pc_sat     = (|csr_writedata[31:ADDR_W]) ? PTR_MAX : csr_writedata[ADDR_W-1:0];
  assign w_capture    = sample_valid && !w_abort &&
                        ((r_state == S_ARMED) || (r_state == S_POST));
  assign w_trig       = w_capture && (r_state == S_ARMED) && trig_in;
  assign w_post_last  = w_capture && (r_state == S_POST) && (r_post_cnt == ADDR_W'(1));
  assign w_enter_done = (w_trig && (r_post_count == '0)) || w_post_last;

`ifdef CURRCTRL_CAPTURE_TIMESTAMP_EN
  logic [7:0] r_ts;

  // Free-running timestamp, restarted by an accepted ARM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_ts <= 8'd0;
    else if (w_arm) r_ts <= 8'd0;
    else            r_ts <= r_ts + 8'd1;
  end

  assign w_wdata = DATA_W'({r_ts, sample_data[23:0]});
`else
  assign w_wdata = sample_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_wr_ptr        <= '0;
      r_post_cnt      <= '0;
      r_post_count    <= '0;
      r_trig_addr     <= '0;
      r_wrapped       <= 1'b0;
      r_triggered     <= 1'b0;
      r_irq           <= 1'b0;
      r_done_pulse    <= 1'b0;
      r_ram_write     <= 1'b0;
      r_ram_address   <= '0;
      r_ram_writedata <= '0;
    end else begin
      r_ram_write  <= w_capture;
      r_done_pulse <= w_enter_done;
      if (w_capture) begin
        r_ram_address   <= r_wr_ptr;
        r_ram_writedata <= w_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == PTR_MAX) r_wrapped <= 1'b1;
      end
      // irq rises the cycle after DONE is entered; a set beats a same-cycle clear.
      if (r_done_pulse)   r_irq <= 1'b1;
      else if (w_irq_clr) r_irq <= 1'b0;
      if (w_pc_wr) r_post_count <= w_pc_sat;
      if (w_abort) begin
        r_state <= S_IDLE;
      end else if (w_arm) begin
        r_state     <= S_ARMED;
        r_wr_ptr    <= '0;
        r_wrapped   <= 1'b0;
        r_triggered <= 1'b0;
      end else if (w_trig) begin
        r_trig_addr <= r_wr_ptr;
        r_triggered <= 1'b1;
        r_post_cnt  <= r_post_count;
        r_state     <= (r_post_count == '0) ? S_DONE : S_POST;
      end else if (w_capture && (r_state == S_POST)) begin
        r_post_cnt <= r_post_cnt - 1'b1;
        if (w_post_last) r_state <= S_DONE;
      end
    end
  end

  always_comb begin
    csr_readdata = 32'd0;
    case (csr_address)
      2'd1:    csr_readdata = 32'(r_post_count);
      2'd2:    csr_readdata = {28'd0, r_triggered, r_wrapped, r_state};
      2'd3:    csr_readdata = 32'(r_trig_addr);
      default: csr_readdata = 32'd0;
    endcase
  end

  assign ram_chipselect = r_ram_write;
  assign ram_write      = r_ram_write;
  assign ram_address    = r_ram_address;
  assign ram_writedata  = r_ram_writedata;
  assign ram_byteenable = 4'hF;
  assign irq            = r_irq;

endmodule

// File: tb/tb_currctrl_debug_capture_ctrl.sv
// Self-checking bench for currctrl_debug_capture_ctrl: directed scenarios plus randomized captures
// checked against a transaction-level model of the capture rules.
module tb_currctrl_debug_capture_ctrl;

  localparam int IDLE_S = 0, ARMED_S = 1, POST_S = 2, DONE_S = 3;

  typedef struct packed {
    logic [8:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        trig_in;
  logic [1:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        ram_chipselect;
  logic        ram_write;
  logic [8:0]  ram_address;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable;
  logic        irq;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;

  // Model state, advanced per CSR command / per sample rather than per cycle.
  int m_state, m_ptr, m_pc, m_remain, m_trig_addr, m_arm_cyc;
  bit m_wrapped, m_trig, m_irq;
  wr_t got_q[$];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  currctrl_debug_capture_ctrl dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_in(trig_in), .csr_address(csr_address), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_address(ram_address),
    .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable), .irq(irq)
  );

  always @(negedge clk) begin
    if (ram_write) got_q.push_back({ram_address, ram_writedata});
    if (ram_write || ram_chipselect) begin
      n_checks++;
      if (ram_chipselect !== ram_write || ram_byteenable !== 4'hF) begin
        n_err++;
        $display("FAIL ram_strobes: cs=%b wr=%b be=%h required cs=wr be=F",
                 ram_chipselect, ram_write, ram_byteenable);
      end
    end
  end

  function automatic logic [31:0] exp_data(input logic [31:0] d);
`ifdef CURRCTRL_CAPTURE_TIMESTAMP_EN
    return {8'(cyc_n - m_arm_cyc - 1), d[23:0]};
`else
    return d;
`endif
  endfunction

  function automatic void m_reset();
    m_state = IDLE_S; m_ptr = 0; m_pc = 0; m_remain = 0; m_trig_addr = 0;
    m_wrapped = 0; m_trig = 0; m_irq = 0;
  endfunction

  function automatic void m_csr(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd0) begin
      if (d[1]) m_state = IDLE_S;
      else if (d[0] && (m_state == IDLE_S || m_state == DONE_S)) begin
        m_state = ARMED_S; m_ptr = 0; m_wrapped = 0; m_trig = 0; m_arm_cyc = cyc_n;
      end
      if (d[2]) m_irq = 0;
    end else if (a == 2'd1 && (m_state == IDLE_S || m_state == DONE_S)) begin
      m_pc = (d > 32'd511) ? 511 : int'(d);
    end
  endfunction

  function automatic void m_sample(input logic [31:0] d, input logic t);
    if (m_state == ARMED_S || m_state == POST_S) begin
      exp_q.push_back({9'(m_ptr), exp_data(d)});
      if (m_state == ARMED_S && t) begin
        m_trig_addr = m_ptr; m_trig = 1;
        if (m_pc == 0) begin m_state = DONE_S; m_irq = 1; end
        else begin m_remain = m_pc; m_state = POST_S; end
      end else if (m_state == POST_S) begin
        m_remain--;
        if (m_remain == 0) begin m_state = DONE_S; m_irq = 1; end
      end
      m_ptr = (m_ptr + 1) % 512;
      if (m_ptr == 0) m_wrapped = 1;
    end
  endfunction

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    cyc();
    csr_write = 1'b0;
    m_csr(a, d);
  endtask

  task automatic send(input logic [31:0] d, input logic t);
    sample_valid = 1'b1; sample_data = d; trig_in = t;
    cyc();
    sample_valid = 1'b0; trig_in = 1'b0;
    m_sample(d, t);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a;
    #1;
    d = csr_readdata;
  endtask

  task automatic start_clean();
    csr_wr(2'd0, 32'h6);
    cyc(); cyc();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; sample_valid = 0; sample_data = 0; trig_in = 0;
    csr_address = 0; csr_write = 0; csr_writedata = 0;
    m_reset();
    repeat (3) cyc();
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h required 0", v); end
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_post_count: got %h required 0", v); end
    n_checks++;
    if ({ram_write, ram_chipselect, irq} !== 3'b0 || ram_address !== 9'd0 || ram_writedata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: wr=%b cs=%b irq=%b addr=%h data=%h required all 0",
               ram_write, ram_chipselect, irq, ram_address, ram_writedata);
    end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_trigger_post();
    logic [31:0] v;
    start_clean();
    csr_wr(2'd1, 32'd4);
    csr_wr(2'd0, 32'h1);
    for (int i = 0; i < 10; i++) send(32'h1000 + 32'(i), i == 5);
    cyc(); cyc();
    n_checks++;
    if (got_q.size() != 10) begin n_err++; $display("FAIL trig_post_count: got %0d writes required 10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      n_checks++;
      if (got_q[i] !== wr_t'({9'(i), 32'h1000 + 32'(i)}) && exp_data(0) == 32'd0 || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL trig_post_write%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    rd(2'd3, v);
    n_checks++;
    if (v !== 32'd5) begin n_err++; $display("FAIL trig_addr: got %0d required 5", v); end
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0B || irq !== 1'b1) begin n_err++; $display("FAIL trig_done: status=%h irq=%b required 0B/1", v, irq); end
  endtask

  task automatic test_post_zero_irq();
    logic [31:0] v;
    start_clean();
    csr_wr(2'd1, 32'd0);
    csr_wr(2'd0, 32'h1);
    send(32'hCAFE0001, 1'b1);
    rd(2'd2, v);
    n_checks++;
    if (ram_write !== 1'b1 || ram_address !== 9'd0 || v[1:0] !== 2'd3 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL pc0_first_cycle: wr=%b addr=%h state=%0d irq=%b required 1/0/3/0", ram_write, ram_address, v[1:0], irq);
    end
    cyc();
    n_checks++;
    if (irq !== 1'b1 || ram_write !== 1'b0) begin
      n_err++; $display("FAIL pc0_irq_next: irq=%b wr=%b required 1/0", irq, ram_write);
    end
    csr_wr(2'd0, 32'h4);
    n_checks++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b required 0", irq); end
    csr_wr(2'd0, 32'h1);
    send(32'hCAFE0002, 1'b1);
    csr_wr(2'd0, 32'h4);
    n_checks++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b required 1", irq); end
    csr_wr(2'd0, 32'h4);
    n_checks++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear2: got %b required 0", irq); end
    cyc(); cyc();
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1] || got_q[1].a !== 9'd0) begin
      n_err++; $display("FAIL pc0_writes: got %0d writes required 2 at addr 0", got_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    int          bad;
    start_clean();
    csr_wr(2'd0, 32'h1);
    for (int i = 0; i < 515; i++) send($urandom, 1'b0);
    cyc(); cyc();
    bad = 0;
    if (got_q.size() != exp_q.size()) bad++;
    else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0 || exp_q.size() != 515) begin
      n_err++; $display("FAIL wrap_writes: got %0d writes, %0d bad, required 515 matching", got_q.size(), bad);
    end
    rd(2'd2, v);
    n_checks++;
    if (ram_address !== 9'd2 || v !== 32'h5 || irq !== 1'b0) begin
      n_err++; $display("FAIL wrap_state: addr=%0d status=%h irq=%b required 2/05/0", ram_address, v, irq);
    end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    start_clean();
    csr_wr(2'd1, 32'd10);
    csr_wr(2'd0, 32'h1);
    send(32'h11, 1'b1);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    csr_wr(2'd0, 32'h2);
    rd(2'd2, v);
    n_checks++;
    if (v[1:0] !== 2'd0) begin n_err++; $display("FAIL abort_idle: state=%0d required 0", v[1:0]); end
    for (int i = 0; i < 3; i++) send(32'h44 + 32'(i), 1'b1);
    repeat (3) cyc();
    n_checks++;
    if (got_q.size() != 3 || got_q[2] !== exp_q[2] || irq !== 1'b0) begin
      n_err++; $display("FAIL abort_no_writes: got %0d writes irq=%b required 3/0", got_q.size(), irq);
    end
    csr_wr(2'd0, 32'h3);
    rd(2'd2, v);
    n_checks++;
    if (v[1:0] !== 2'(m_state) || v[1:0] !== 2'd0) begin
      n_err++; $display("FAIL arm_abort_same: state=%0d required 0", v[1:0]);
    end
  endtask

  task automatic test_post_count_csr();
    logic [31:0] v;
    start_clean();
    csr_wr(2'd1, 32'hFFFF);
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'h1FF) begin n_err++; $display("FAIL pc_saturate: got %h required 1FF", v); end
    csr_wr(2'd0, 32'h1);
    csr_wr(2'd1, 32'd3);
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'h1FF) begin n_err++; $display("FAIL pc_armed_locked: got %h required 1FF", v); end
    send(32'h55, 1'b1);
    csr_wr(2'd1, 32'd3);
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'h1FF) begin n_err++; $display("FAIL pc_post_locked: got %h required 1FF", v); end
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'hA) begin n_err++; $display("FAIL pc_post_status: got %h required 0A", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    start_clean();
    csr_wr(2'd1, 32'd7);
    csr_wr(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) send(32'h700 + 32'(i), i == 2);
    cyc();
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0 || ram_write !== 1'b0 || ram_address !== 9'd0 || ram_writedata !== 32'd0 || irq !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: status=%h wr=%b addr=%h data=%h irq=%b required all 0",
                        v, ram_write, ram_address, ram_writedata, irq);
    end
    rd(2'd3, v);
    n_checks++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_mid_trig_addr: got %h required 0", v); end
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_mid_post_count: got %h required 0", v); end
    cyc();
    reset_n = 1'b1;
    cyc();
    n_checks++;
    if (got_q.size() != 5 || got_q[4] !== exp_q[4]) begin
      n_err++; $display("FAIL reset_mid_writes: got %0d writes required 5", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    int          bad;
    for (int it = 0; it < 8; it++) begin
      start_clean();
      csr_wr(2'd1, ($urandom_range(0, 7) == 0) ? 32'hFFFF : 32'($urandom_range(0, 12)));
      csr_wr(2'd0, 32'h1);
      for (int s = 0, n = $urandom_range(1, 40); s < n; s++) begin
        repeat ($urandom_range(0, 2)) cyc();
        if ($urandom_range(0, 39) == 0) csr_wr(2'd0, 32'h2);
        send($urandom, $urandom_range(0, 7) == 0);
      end
      cyc(); cyc();
      bad = 0;
      if (got_q.size() != exp_q.size()) bad++;
      else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_err++; $display("FAIL rand%0d_writes: got %0d writes required %0d, %0d bad", it, got_q.size(), exp_q.size(), bad);
      end
      rd(2'd2, v);
      n_checks++;
      if (v !== {28'd0, m_trig, m_wrapped, 2'(m_state)} || irq !== m_irq) begin
        n_err++; $display("FAIL rand%0d_status: status=%h irq=%b required %h/%b", it, v, irq,
                          {28'd0, m_trig, m_wrapped, 2'(m_state)}, m_irq);
      end
      rd(2'd3, v);
      n_checks++;
      if (m_trig && v !== 32'(m_trig_addr)) begin
        n_err++; $display("FAIL rand%0d_trig_addr: got %0d required %0d", it, v, m_trig_addr);
      end
    end
  endtask

`ifdef CURRCTRL_CAPTURE_TIMESTAMP_EN
  task automatic test_timestamp();
    start_clean();
    csr_wr(2'd0, 32'h1);
    cyc(); cyc();
    send(32'hAABBCCDD, 1'b0);
    n_checks++;
    if (ram_write !== 1'b1 || ram_writedata !== 32'h02BBCCDD) begin
      n_err++; $display("FAIL timestamp: wr=%b data=%h required 1/02BBCCDD", ram_write, ram_writedata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_trigger_post();
    test_post_zero_irq();
    test_wrap();
    test_abort();
    test_post_count_csr();
    test_reset_mid();
    test_random();
`ifdef CURRCTRL_CAPTURE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/currctrl_debug_capture_ctrl.md
CURRCTRL_DEBUG_CAPTURE_CTRL -- requirements
Module: currctrl_debug_capture_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, debug RAM word-address width (512 words).
REQ-002 Parameter DATA_W, default 32, sample and RAM data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock, all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 sample_valid  in  1  one-cycle strobe; sample_data is valid.
REQ-006 sample_data  in  DATA_W  current-control debug sample.
REQ-007 trig_in  in  1  trigger qualifier, sampled only with sample_valid.
REQ-008 csr_address  in  2  CSR word select.
REQ-009 csr_write  in  1  CSR write strobe.
REQ-010 csr_writedata  in  32  CSR write data.
REQ-011 csr_readdata  out  32  CSR read data, combinational from csr_address.
REQ-012 ram_chipselect, ram_write  out  1 each  debug RAM write-port strobes, always equal.
REQ-013 ram_address  out  ADDR_W  debug RAM write address.
REQ-014 ram_writedata  out  DATA_W  debug RAM write data; ram_byteenable  out  4  tied to 4'hF.
REQ-015 irq  out  1  capture-complete interrupt, level, sticky.

Function
REQ-016 CSR map SHALL be: 0 CTRL (W: bit0 ARM, bit1 ABORT, bit2 IRQ_CLR; R: 0); 1 POST_COUNT (R/W, bits ADDR_W-1:0); 2 STATUS (R: bits1:0 state, bit2 wrapped, bit3 triggered); 3 TRIG_ADDR (R).
REQ-017 States SHALL be IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-018 ARM in IDLE or DONE SHALL go to ARMED next cycle, clear wr_ptr, wrapped, triggered; ARM in ARMED/POST SHALL be ignored.
REQ-019 ABORT SHALL force IDLE from any state next cycle without setting irq; ABORT wins over simultaneous ARM.
REQ-020 In ARMED/POST each sample_valid SHALL produce one RAM write exactly one cycle later at address wr_ptr, then wr_ptr increments modulo 2^ADDR_W.
REQ-021 wr_ptr wrap 2^ADDR_W-1 -> 0 SHALL set wrapped (sticky until next ARM).
REQ-022 ARMED with sample_valid & trig_in SHALL write that sample, latch TRIG_ADDR=wr_ptr, set triggered, load post counter from POST_COUNT, go POST; if POST_COUNT=0 go directly to DONE.
REQ-023 POST SHALL decrement the counter per written sample; the write that takes it to 0 SHALL move to DONE.
REQ-024 POST_COUNT SHALL saturate at 2^ADDR_W-1 so the trigger sample is never overwritten.
REQ-025 Entry to DONE SHALL set irq the next cycle; IRQ_CLR clears it; set and clear in the same cycle: set wins.
REQ-026 POST_COUNT writes SHALL be ignored in ARMED and POST.
REQ-027 IDLE and DONE SHALL issue no RAM writes; trig_in without sample_valid SHALL be ignored.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, wr_ptr 0, post counter 0, POST_COUNT 0, TRIG_ADDR 0, wrapped 0, triggered 0, irq 0, ram_write/ram_chipselect 0, ram_address 0, ram_writedata 0.
REQ-029 Reset mid-capture SHALL abandon the capture; RAM contents are not cleared.

Configuration
REQ-030 Macro CURRCTRL_CAPTURE_TIMESTAMP_EN defined: ram_writedata = {ts[7:0], sample_data[23:0]}, ts an 8-bit free-running counter, cleared on ARM and reset, incremented every clk, wrapping 255->0.
REQ-031 Macro undefined: ram_writedata = sample_data unchanged; no timestamp logic present.

Verification
REQ-032 POST_COUNT=4, ARM, 10 samples, trig_in on 6th -> writes addr 0..9, TRIG_ADDR=5, state DONE, irq=1, STATUS=0x0B.
REQ-033 POST_COUNT=0, ARM, trigger on 1st sample -> single write addr 0, DONE, irq next cycle.
REQ-034 ARM, 515 samples, no trigger -> final address 2, wrapped=1, state ARMED, irq=0.
REQ-035 ARM, trigger, ABORT in POST after 2 samples -> IDLE next cycle, no further writes, irq=0; simultaneous ARM+ABORT -> IDLE.
REQ-036 POST_COUNT write 0xFFFF -> reads 0x1FF; write 3 during POST -> value unchanged.
REQ-037 TIMESTAMP_EN defined, ARM then sample 3 cycles later with data 0xAABBCCDD -> ram_writedata top byte equals ts at capture, low 24 bits 0xBBCCDD.
